// File: rtl/mdu.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (9-12).
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] MDUOut
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      phi_q, phi_d;
    logic [31:0]      plo_q, plo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ---------------- decode ----------------
    logic is_mul, is_div, is_madd, is_signed, is_mc;

    assign is_mul    = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign is_div    = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign is_signed = (MDUOp == OP_MULT) || (MDUOp == OP_DIV) ||
                       (MDUOp == OP_MADD) || (MDUOp == OP_MSUB);
    assign is_mc     = is_mul || is_div || is_madd;

    // ---------------- multiplier ----------------
    // One 64x64 truncated multiply serves signed and unsigned forms: the
    // operands are sign- or zero-extended first, and only the low 64 bits matter.
    logic [63:0] a_ext, b_ext, prod;

    assign a_ext = {{32{is_signed & A[31]}}, A};
    assign b_ext = {{32{is_signed & B[31]}}, B};
    assign prod  = a_ext * b_ext;

    // ---------------- divider ----------------
    // Divide magnitudes unsigned, then restore signs; this keeps 0x80000000/-1
    // well defined (quotient wraps to 0x80000000, remainder 0).
    logic        a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag, quo, rem;

    assign a_neg    = is_signed & A[31];
    assign b_neg    = is_signed & B[31];
    assign a_mag    = a_neg ? (32'd0 - A) : A;
    assign b_mag    = b_neg ? (32'd0 - B) : B;
    assign div_zero = (B == 32'd0);
    assign b_safe   = div_zero ? 32'd1 : b_mag;
    assign q_mag    = a_mag / b_safe;
    assign r_mag    = a_mag % b_safe;
    assign quo      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

    // ---------------- multiply-accumulate ----------------
    logic [63:0] madd_res;

`ifdef MDU_MADD_EN
    logic madd_sub;

    assign is_madd  = (MDUOp == OP_MADD) || (MDUOp == OP_MADDU) ||
                      (MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU);
    assign madd_sub = (MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU);
    assign madd_res = madd_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`else
    assign is_madd  = 1'b0;
    assign madd_res = 64'd0;
`endif

    // ---------------- next state ----------------
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            // In-flight op has already retired past E, so Req cannot cancel it.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (!Req) begin
            if (Start && is_mc) begin
                cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                if (is_div) begin
                    // Divide by zero commits the old HI/LO, i.e. leaves them unchanged.
                    phi_d = div_zero ? hi_q : rem;
                    plo_d = div_zero ? lo_q : quo;
                end else if (is_madd) begin
                    phi_d = madd_res[63:32];
                    plo_d = madd_res[31:0];
                end else begin
                    phi_d = prod[63:32];
                    plo_d = prod[31:0];
                end
            end else if (MDUOp == OP_MTHI) begin
                hi_d = A;
            end else if (MDUOp == OP_MTLO) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            phi_q <= 32'd0;
            plo_q <= 32'd0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            cnt_q <= cnt_d;
        end
    end

    // ---------------- outputs ----------------
    assign Busy = (cnt_q != '0);

    always_comb begin
        MDUOut = 32'd0;
        case (MDUOp)
            OP_MFHI: MDUOut = hi_q;
            OP_MFLO: MDUOut = lo_q;
            OP_NONE: MDUOut = 32'd0;
            default: MDUOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: HI/LO results, Busy timing, Req/reset behaviour.
module tb_mdu;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;

`ifdef MDU_MADD_EN
    localparam logic MADD_ON = 1'b1;
`else
    localparam logic MADD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUOp;
    logic        Start, Req;
    logic        Busy;
    logic [31:0] MDUOut;

    int total = 0;
    int fails = 0;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .Req    (Req),
        .Busy   (Busy),
        .MDUOut (MDUOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic st);
        MDUOp = op; A = a; B = b; Start = st;
        step();
        MDUOp = OP_NONE; A = 32'd0; B = 32'd0; Start = 1'b0;
    endtask

    task automatic rd(input logic [3:0] op, output logic [31:0] v);
        MDUOp = op;
        #1;
        v = MDUOut;
        MDUOp = OP_NONE;
        #1;
    endtask

    task automatic chk_hl(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        logic [31:0] v;
        rd(OP_MFHI, v);
        chk({tag, ".hi"}, v, hi);
        rd(OP_MFLO, v);
        chk({tag, ".lo"}, v, lo);
    endtask

    // Counts cycles with Busy high, starting from the current cycle.
    task automatic busy_len(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] v;
        reset = 1'b1; A = 32'd0; B = 32'd0; MDUOp = OP_NONE; Start = 1'b0; Req = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset.busy", {31'd0, Busy}, 32'd0);
        chk_hl("reset", 32'd0, 32'd0);

        issue(OP_MULT, 32'h8000_0000, 32'd2, 1'b1);
        busy_len(n);
        chk("mult.busy", 32'(n), 32'd5);
        chk_hl("mult", 32'hFFFF_FFFF, 32'h0000_0000);

        issue(OP_MULTU, 32'h8000_0000, 32'd2, 1'b1);
        busy_len(n);
        chk("multu.busy", 32'(n), 32'd5);
        chk_hl("multu", 32'h0000_0001, 32'h0000_0000);

        MDUOp = OP_NONE;
        #1;
        chk("none.out", MDUOut, 32'd0);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        busy_len(n);
        chk("div.busy", 32'(n), 32'd10);
        chk_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(OP_DIVU, 32'd7, 32'd2, 1'b1);
        busy_len(n);
        chk("divu.busy", 32'(n), 32'd10);
        chk_hl("divu", 32'd1, 32'd3);

        issue(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        rd(OP_MFHI, v);
        chk("mthi", v, 32'h1234);
        issue(OP_MTLO, 32'h5678, 32'd0, 1'b0);
        rd(OP_MFLO, v);
        chk("mtlo", v, 32'h5678);

        issue(OP_DIV, 32'd99, 32'd0, 1'b1);
        busy_len(n);
        chk("div0.busy", 32'(n), 32'd10);
        chk_hl("div0", 32'h1234, 32'h5678);

        Req = 1'b1;
        issue(OP_MULT, 32'd5, 32'd5, 1'b1);
        Req = 1'b0;
        chk("reqstart.busy", {31'd0, Busy}, 32'd0);
        chk_hl("reqstart", 32'h1234, 32'h5678);

        issue(OP_13_as_none(), 32'd5, 32'd5, 1'b1);
        chk("op13.busy", {31'd0, Busy}, 32'd0);

        // MULT 3*4, then a Start and an MTHI while busy (the MTHI with Req).
        issue(OP_MULT, 32'd3, 32'd4, 1'b1);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        Req = 1'b1;
        issue(OP_MTHI, 32'hDEAD, 32'd0, 1'b0);
        Req = 1'b0;
        busy_len(n);
        chk("reqbusy.busy", 32'(n + 2), 32'd5);
        chk_hl("reqbusy", 32'd0, 32'd12);

        issue(OP_DIV, 32'd100, 32'd7, 1'b1);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstbusy.busy", {31'd0, Busy}, 32'd0);
        chk_hl("rstbusy", 32'd0, 32'd0);
        repeat (12) step();
        chk("rstlate.busy", {31'd0, Busy}, 32'd0);
        chk_hl("rstlate", 32'd0, 32'd0);

        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(OP_MADDU, 32'd1, 32'd1, 1'b1);
        busy_len(n);
        if (MADD_ON) begin
            chk("maddu.busy", 32'(n), 32'd5);
            chk_hl("maddu", 32'd1, 32'd0);
        end else begin
            chk("maddu.busy", 32'(n), 32'd0);
            chk_hl("maddu", 32'd0, 32'hFFFF_FFFF);
        end

        issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
        issue(OP_MTLO, 32'd0, 32'd0, 1'b0);
        issue(OP_MSUB, 32'd1, 32'd2, 1'b1);
        busy_len(n);
        if (MADD_ON) begin
            chk("msub.busy", 32'(n), 32'd5);
            chk_hl("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        end else begin
            chk("msub.busy", 32'(n), 32'd0);
            chk_hl("msub", 32'd0, 32'd0);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    function automatic logic [3:0] OP_13_as_none();
        return 4'd13;
    endfunction

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the execute stage, beside the ALU. It takes the same forwarded E-stage operands and runs the multi-cycle HI/LO instructions: mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It also runs madd/msub when configured in. The result feeds the E-stage result mux and then the E/M pipeline register. A Busy output lets the hazard unit stall the D stage.

## Interface
- `MULT_CYCLES`, 5, Busy cycles for multiply-class ops (≥1).
- `DIV_CYCLES`, 10, Busy cycles for divide-class ops (≥1).
- `clk`  in  1  Clock; all state changes on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `A`  in  32  rs operand (forwarded).
- `B`  in  32  rt operand (forwarded).
- `MDUOp`  in  4  Operation code:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
  - 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
  - 13–15 are treated as NONE.
- `Start`  in  1  Qualifies ops 1–4 and 9–12 this cycle.
- `Req`  in  1  Exception/interrupt flush: the E-stage instruction must not commit.
- `Busy`  out  1  Registered; high while an operation is in flight.
- `MDUOut`  out  32  Combinational: HI for MFHI, LO for MFLO, otherwise 0.

## Operation
- State: `HI[31:0]`, `LO[31:0]`, a count-down counter `cnt`, and pending result registers `pHI` and `pLO`.
- Busy = (cnt != 0).
- **Start accepted** when Start=1, Busy=0, Req=0 and MDUOp is a multi-cycle op. The result is computed from A/B at that edge into pHI/pLO. cnt loads MULT_CYCLES or DIV_CYCLES.
- **Start ignored** when Busy=1 or Req=1. Start with a non-multi-cycle MDUOp is also ignored.
- **Results:**
  - MULT: {pHI,pLO} = $signed(A) × $signed(B), 64-bit.
  - MULTU: unsigned 64-bit product.
  - DIV: pLO = signed quotient truncated toward zero; pHI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- **Divide by zero** (B=0): runs the full DIV_CYCLES; HI/LO keep their previous values.
- **Completion:** each cycle with cnt != 0, cnt decrements. On the edge where cnt goes 1→0, HI/LO take pHI/pLO.
- **MTHI/MTLO:** HI or LO ← A at the edge, only when Busy=0 and Req=0; otherwise ignored. Start is not required.
- **MFHI/MFLO** read the current architectural HI/LO. While Busy=1 the hazard unit stalls them; the MDU itself does no gating.
- **Req while Busy=1:** the in-flight op continues and commits; it was already retired past E.
- **Reset:** HI=0, LO=0, cnt=0, pHI=pLO=0, Busy=0. An in-flight operation is discarded.

## Timing
- Start accepted at edge *t*:
  - Busy is high from *t* through *t+N−1*, where N is the latency.
  - HI/LO show the new values, and Busy=0, after edge *t+N*.
  - With defaults: mult-class ops take 5 busy cycles; div-class ops take 10.
- The hazard unit stalls on (Busy | Start). Back-to-back ops are therefore separated by at least N cycles of Busy.
- An MFHI issued immediately after completion reads the new value with no extra bubble.
- MTHI/MTLO take effect at their own edge; an MFHI in the next cycle returns A.
- MDUOut has zero latency (combinational from HI/LO/MDUOp).
- Reset values: Busy=0; MDUOut=0 (HI=LO=0).

## Configuration
- `MDU_MADD_EN` defined:
  - Ops 9–12 are valid and use MULT_CYCLES.
  - MADD: {pHI,pLO} = {HI,LO} + signed product. MADDU: + unsigned product.
  - MSUB: {pHI,pLO} = {HI,LO} − signed product. MSUBU: − unsigned product.
  - All mod 2^64, using HI/LO as they stand at Start.
- Undefined: ops 9–12 are treated as NONE. Start with them is ignored; Busy stays 0 and HI/LO are unchanged.

## Test plan
- Reset, then MULT with A=0x80000000, B=2 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0x00000000. The same operands with MULTU → HI=0x00000001, LO=0.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- MTHI A=0x1234 and MTLO A=0x5678 → MFHI returns 0x1234 and MFLO returns 0x5678 in the next cycles. Then DIV by B=0 → 10 Busy cycles; HI/LO remain 0x1234/0x5678.
- Req=1 together with Start (MULT) → Busy stays 0, HI/LO unchanged. Req=1 on the second Busy cycle of a MULT → the op still completes on schedule. Start or MTHI during Busy → ignored.
- reset asserted on the third Busy cycle of a DIV → the next cycle has Busy=0, HI=LO=0, and no later update occurs.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 → HI=1, LO=0. MSUB A=1, B=2 from HI=LO=0 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. Without the macro, the same stimulus leaves HI/LO unchanged and Busy=0.
